// File: rtl/lsu_sequencer_if.sv
// Load/store unit bus between the datapath, the caches and lsu_sequencer.
// slave modport is the sequencer's view; master is the datapath/cache side.
interface lsu_sequencer_if #(
    parameter int THREADS = 4,
    parameter int WORD_W  = 32
);
    // instruction path
    logic                           instReq;
    logic [WORD_W-1:0]              iaddr;
    logic                           iHit;
    logic [WORD_W-1:0]              iload;
    logic                           imemREN;
    logic [WORD_W-1:0]              imemaddr;
    logic [WORD_W-1:0]              imemload;
    logic                           icacheHit;
    // data requests from the datapath
    logic                           readReq;
    logic                           writeReq;
    logic                           isVector;
    logic [WORD_W-1:0]              sdaddr;
    logic [WORD_W-1:0]              sdstore;
    logic [THREADS-1:0][WORD_W-1:0] vdaddr;
    logic [THREADS-1:0][WORD_W-1:0] vdstore;
    logic                           dhalt;
    logic                           dHit;
    logic [WORD_W-1:0]              sdload;
    logic [THREADS-1:0][WORD_W-1:0] vdload;
    // data cache port
    logic                           dmemREN;
    logic                           dmemWEN;
    logic [WORD_W-1:0]              dmemaddr;
    logic [WORD_W-1:0]              dmemstore;
    logic [WORD_W-1:0]              dmemload;
    logic                           dcacheHit;
    // halt / flush handshake
    logic                           chalt;
    logic                           flushed;

    modport slave (
        input  instReq, iaddr, imemload, icacheHit,
        input  readReq, writeReq, isVector, sdaddr, sdstore, vdaddr, vdstore, dhalt,
        input  dmemload, dcacheHit, flushed,
        output iHit, iload, imemREN, imemaddr,
        output dHit, sdload, vdload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, chalt
    );

    modport master (
        output instReq, iaddr, imemload, icacheHit,
        output readReq, writeReq, isVector, sdaddr, sdstore, vdaddr, vdstore, dhalt,
        output dmemload, dcacheHit, flushed,
        input  iHit, iload, imemREN, imemaddr,
        input  dHit, sdload, vdload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, chalt
    );
endinterface

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: serializes scalar and per-lane vector accesses onto
// the single dcache port, returns load data and a one-cycle dHit, and parks
// in HALT (chalt high) once the datapath halts.
// Optional feature: define LSU_COALESCE_EN to skip cache accesses for vector
// read lanes whose address repeats the previous lane's address.
module lsu_sequencer #(
    parameter int THREADS = 4,
    parameter int WORD_W  = 32
) (
    input logic              CLK,
    input logic              RST,
    lsu_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE, HALT} state_t;

    localparam int LANE_W = (THREADS > 1) ? $clog2(THREADS) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(THREADS - 1);

    state_t                         state;
    state_t                         state_next;
    logic [LANE_W-1:0]              lane;
    logic [LANE_W-1:0]              lane_next;
    logic                           vec_q;
    logic                           vec_next;
    logic                           wr_q;
    logic                           wr_next;
    logic [WORD_W-1:0]              sd_q;
    logic [THREADS-1:0][WORD_W-1:0] vd_q;

    logic              req_any;
    logic              active;
    logic              coalesce;
    logic              advance;
    logic              last_lane;
    logic [WORD_W-1:0] lane_addr;
    logic [WORD_W-1:0] lane_store;

    assign req_any    = bus.readReq | bus.writeReq;
    // An access only makes progress while the datapath still requests it;
    // a dropped request is an abort and wins over a coincident cache hit.
    assign active     = (state == ACCESS) && req_any;
    assign lane_addr  = vec_q ? bus.vdaddr[lane]  : bus.sdaddr;
    assign lane_store = vec_q ? bus.vdstore[lane] : bus.sdstore;
    assign last_lane  = !vec_q || (lane == LAST_LANE);

`ifdef LSU_COALESCE_EN
    logic [LANE_W-1:0] prev_lane;
    assign prev_lane = lane - LANE_W'(1);
    assign coalesce  = (state == ACCESS) && vec_q && !wr_q && (lane != '0)
                     && (bus.vdaddr[lane] == bus.vdaddr[prev_lane]);
`else
    assign coalesce  = 1'b0;
`endif

    assign advance = coalesce || bus.dcacheHit;

    // Instruction path runs alongside data accesses; only HALT blocks fetches.
    assign bus.iHit     = bus.instReq & bus.icacheHit;
    assign bus.iload    = bus.imemload;
    assign bus.imemaddr = bus.iaddr;
    assign bus.imemREN  = bus.instReq & (state != HALT);
    assign bus.dHit     = (state == DONE);
    assign bus.chalt    = (state == HALT);
    assign bus.sdload   = sd_q;
    assign bus.vdload   = vd_q;

    // Cache port is driven only in ACCESS, held stable until the cache hits.
    always_comb begin
        bus.dmemREN   = 1'b0;
        bus.dmemWEN   = 1'b0;
        bus.dmemaddr  = '0;
        bus.dmemstore = '0;
        if (state == ACCESS) begin
            bus.dmemaddr  = lane_addr;
            bus.dmemstore = lane_store;
            bus.dmemREN   = !wr_q && !coalesce;
            bus.dmemWEN   = wr_q;
        end
    end

    // Next-state, lane stepping and request latching.
    always_comb begin
        state_next = state;
        lane_next  = lane;
        vec_next   = vec_q;
        wr_next    = wr_q;
        case (state)
            IDLE: begin
                if (bus.dhalt) begin
                    state_next = HALT;
                end else if (req_any) begin
                    state_next = ACCESS;
                    lane_next  = '0;
                    vec_next   = bus.isVector;
                    wr_next    = bus.writeReq;
                end
            end
            ACCESS: begin
                if (!req_any) begin
                    state_next = IDLE;
                end else if (advance) begin
                    if (last_lane) begin
                        state_next = DONE;
                    end else begin
                        lane_next = lane + LANE_W'(1);
                    end
                end
            end
            DONE:    state_next = IDLE;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            lane  <= '0;
            vec_q <= 1'b0;
            wr_q  <= 1'b0;
        end else begin
            state <= state_next;
            lane  <= lane_next;
            vec_q <= vec_next;
            wr_q  <= wr_next;
        end
    end

    // Load result registers: capture on read hits, copy on coalesced lanes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sd_q <= '0;
            vd_q <= '0;
        end else if (active && !wr_q) begin
            if (coalesce) begin
`ifdef LSU_COALESCE_EN
                vd_q[lane] <= vd_q[prev_lane];
`endif
            end else if (bus.dcacheHit) begin
                if (vec_q) begin
                    vd_q[lane] <= bus.dmemload;
                end else begin
                    sd_q <= bus.dmemload;
                end
            end
        end
    end
endmodule

// File: tb/tb_lsu_sequencer.sv
// Self-checking bench for lsu_sequencer: directed scenarios followed by
// randomized scalar/vector transactions against a transaction-level model.
module tb_lsu_sequencer;
    localparam int THREADS = 4;
    localparam int WORD_W  = 32;
    localparam int CW      = THREADS * WORD_W;
`ifdef LSU_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    typedef logic [WORD_W-1:0] word_t;
    typedef struct {
        bit    rd;
        bit    wr;
        word_t addr;
        word_t store;
        bit    hit;
        int    lane;
        bit    coal;
    } cyc_t;

    logic CLK = 1'b0;
    logic RST;

    lsu_sequencer_if #(.THREADS(THREADS), .WORD_W(WORD_W)) bus ();

    lsu_sequencer #(.THREADS(THREADS), .WORD_W(WORD_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int    n_cmp = 0;
    int    n_bad = 0;
    word_t exp_sd;
    word_t exp_vd  [THREADS];
    word_t t_addr  [THREADS];
    word_t t_store [THREADS];
    int    t_wait  [THREADS];
    cyc_t  sched   [$];

    task automatic checkOutput(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Backing memory contents as seen through the data cache.
    function automatic word_t mem_val(input word_t a);
        return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    task automatic clear_model();
        exp_sd = '0;
        for (int k = 0; k < THREADS; k++) exp_vd[k] = '0;
    endtask

    task automatic check_loads();
        checkOutput("sdload", CW'(bus.sdload), CW'(exp_sd));
        for (int k = 0; k < THREADS; k++)
            checkOutput($sformatf("vdload%0d", k), CW'(bus.vdload[k]), CW'(exp_vd[k]));
    endtask

    // Expected cache-port activity, one entry per ACCESS cycle.
    task automatic build_schedule(input bit vec, input bit wr);
        cyc_t e;
        int   lanes;
        sched.delete();
        lanes = vec ? THREADS : 1;
        for (int k = 0; k < lanes; k++) begin
            e.lane  = k;
            e.addr  = t_addr[k];
            e.store = t_store[k];
            if (COAL && vec && !wr && k > 0 && t_addr[k] == t_addr[k-1]) begin
                e.rd = 1'b0; e.wr = 1'b0; e.hit = 1'b0; e.coal = 1'b1;
                sched.push_back(e);
            end else begin
                for (int w = 0; w <= t_wait[k]; w++) begin
                    e.rd = !wr; e.wr = wr; e.hit = (w == t_wait[k]); e.coal = 1'b0;
                    sched.push_back(e);
                end
            end
        end
    endtask

    // Random instruction-path traffic plus its combinational checks.
    task automatic poke_inst(input bit halted, input bit force_req);
        bit    ir;
        bit    ih;
        word_t ia;
        word_t il;
        ir = force_req ? 1'b1 : 1'(($urandom_range(0, 1)));
        ih = 1'($urandom_range(0, 1));
        ia = $urandom;
        il = $urandom;
        bus.instReq   = ir;
        bus.icacheHit = ih;
        bus.iaddr     = ia;
        bus.imemload  = il;
        #1;
        checkOutput("iHit",     CW'(bus.iHit),     CW'(ir & ih));
        checkOutput("iload",    CW'(bus.iload),    CW'(il));
        checkOutput("imemaddr", CW'(bus.imemaddr), CW'(ia));
        checkOutput("imemREN",  CW'(bus.imemREN),  CW'(ir & !halted));
    endtask

    // kill_kind: 0 none, 1 drop requests, 2 reset; kill_at/halt_at index the schedule.
    task automatic applyStimulus(input bit vec, input bit wr, input int kill_at,
                                 input int kill_kind, input int halt_at);
        build_schedule(vec, wr);
        @(negedge CLK);
        bus.readReq   = !wr;
        bus.writeReq  = wr;
        bus.isVector  = vec;
        bus.sdaddr    = t_addr[0];
        bus.sdstore   = t_store[0];
        for (int k = 0; k < THREADS; k++) begin
            bus.vdaddr[k]  = vec ? t_addr[k]  : word_t'($urandom);
            bus.vdstore[k] = vec ? t_store[k] : word_t'($urandom);
        end
        bus.dcacheHit = 1'b0;
        poke_inst(1'b0, 1'b0);
        for (int i = 0; i < sched.size(); i++) begin
            @(negedge CLK);
            checkOutput("dHit_busy", CW'(bus.dHit),    CW'(0));
            checkOutput("dmemREN",   CW'(bus.dmemREN), CW'(sched[i].rd));
            checkOutput("dmemWEN",   CW'(bus.dmemWEN), CW'(sched[i].wr));
            if (sched[i].rd || sched[i].wr)
                checkOutput("dmemaddr", CW'(bus.dmemaddr), CW'(sched[i].addr));
            if (sched[i].wr)
                checkOutput("dmemstore", CW'(bus.dmemstore), CW'(sched[i].store));
            if (i == halt_at) bus.dhalt = 1'b1;
            if (i == kill_at && kill_kind != 0) begin
                if (kill_kind == 1) begin
                    bus.readReq  = 1'b0;
                    bus.writeReq = 1'b0;
                end else begin
                    RST = 1'b1;
                end
                bus.dcacheHit = 1'($urandom_range(0, 1));
                bus.dmemload  = $urandom;
                @(negedge CLK);
                RST           = 1'b0;
                bus.readReq   = 1'b0;
                bus.writeReq  = 1'b0;
                bus.dcacheHit = 1'b0;
                if (kill_kind == 2) begin
                    clear_model();
                    checkOutput("rst_dmemaddr",  CW'(bus.dmemaddr),  CW'(0));
                    checkOutput("rst_dmemstore", CW'(bus.dmemstore), CW'(0));
                    checkOutput("rst_chalt",     CW'(bus.chalt),     CW'(0));
                end
                checkOutput("kill_dHit",    CW'(bus.dHit),    CW'(0));
                checkOutput("kill_dmemREN", CW'(bus.dmemREN), CW'(0));
                checkOutput("kill_dmemWEN", CW'(bus.dmemWEN), CW'(0));
                check_loads();
                @(negedge CLK);
                checkOutput("kill_dHit_late", CW'(bus.dHit), CW'(0));
                return;
            end
            if (sched[i].coal) begin
                bus.dcacheHit = 1'($urandom_range(0, 1));
                bus.dmemload  = $urandom;
                exp_vd[sched[i].lane] = exp_vd[sched[i].lane - 1];
            end else if (sched[i].hit) begin
                bus.dcacheHit = 1'b1;
                bus.dmemload  = mem_val(sched[i].addr);
                if (sched[i].rd) begin
                    if (vec) exp_vd[sched[i].lane] = mem_val(sched[i].addr);
                    else     exp_sd = mem_val(sched[i].addr);
                end
            end else begin
                bus.dcacheHit = 1'b0;
                bus.dmemload  = $urandom;
            end
            poke_inst(1'b0, 1'b0);
        end
        @(negedge CLK);
        checkOutput("dHit_done",    CW'(bus.dHit),    CW'(1));
        checkOutput("done_dmemREN", CW'(bus.dmemREN), CW'(0));
        checkOutput("done_dmemWEN", CW'(bus.dmemWEN), CW'(0));
        bus.readReq   = 1'b0;
        bus.writeReq  = 1'b0;
        bus.dcacheHit = 1'b0;
        @(negedge CLK);
        checkOutput("dHit_once",  CW'(bus.dHit),  CW'(0));
        checkOutput("chalt_idle", CW'(bus.chalt), CW'(0));
        check_loads();
    endtask

    task automatic do_reset();
        RST           = 1'b1;
        bus.readReq   = 1'b0;
        bus.writeReq  = 1'b0;
        bus.dhalt     = 1'b0;
        bus.flushed   = 1'b0;
        bus.dcacheHit = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        clear_model();
    endtask

    task automatic set_lanes(input word_t a0, input word_t a1, input word_t a2, input word_t a3,
                             input int w0, input int w1, input int w2, input int w3);
        t_addr[0] = a0; t_addr[1] = a1; t_addr[2] = a2; t_addr[3] = a3;
        t_wait[0] = w0; t_wait[1] = w1; t_wait[2] = w2; t_wait[3] = w3;
        for (int k = 0; k < THREADS; k++) t_store[k] = $urandom;
    endtask

    // Watchdog: every phase is cycle-bounded, this only catches a stuck run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.instReq   = 1'b0;
        bus.iaddr     = '0;
        bus.imemload  = '0;
        bus.icacheHit = 1'b0;
        bus.isVector  = 1'b0;
        bus.sdaddr    = '0;
        bus.sdstore   = '0;
        bus.vdaddr    = '0;
        bus.vdstore   = '0;
        bus.dmemload  = '0;
        do_reset();
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("reset_dHit",      CW'(bus.dHit),      CW'(0));
        checkOutput("reset_chalt",     CW'(bus.chalt),     CW'(0));
        checkOutput("reset_dmemREN",   CW'(bus.dmemREN),   CW'(0));
        checkOutput("reset_dmemWEN",   CW'(bus.dmemWEN),   CW'(0));
        checkOutput("reset_dmemaddr",  CW'(bus.dmemaddr),  CW'(0));
        checkOutput("reset_dmemstore", CW'(bus.dmemstore), CW'(0));
        check_loads();
        RST = 1'b0;

        // scalar read, zero-wait cache
        set_lanes(32'h40, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, -1, 0, -1);
        // vector read, lane 2 misses three cycles
        set_lanes(32'h0, 32'h4, 32'h8, 32'hC, 0, 0, 3, 0);
        applyStimulus(1'b1, 1'b0, -1, 0, -1);
        // vector write with stores 1..4
        set_lanes(32'h100, 32'h104, 32'h108, 32'h10C, 0, 0, 0, 0);
        for (int k = 0; k < THREADS; k++) t_store[k] = word_t'(k + 1);
        applyStimulus(1'b1, 1'b1, -1, 0, -1);
        // vector read with every lane at the same address
        set_lanes(32'h80, 32'h80, 32'h80, 32'h80, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, -1, 0, -1);
        // reset while lane 2 is outstanding
        set_lanes(32'h200, 32'h204, 32'h208, 32'h20C, 0, 0, 2, 0);
        applyStimulus(1'b1, 1'b0, 2, 2, -1);
        // requests dropped during lane 1
        set_lanes(32'h300, 32'h304, 32'h308, 32'h30C, 1, 1, 0, 0);
        applyStimulus(1'b1, 1'b0, 2, 1, -1);
        // scalar write
        set_lanes(32'h44, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, -1, 0, -1);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            bit vec;
            bit wr;
            int kill;
            vec = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            for (int k = 0; k < THREADS; k++) begin
                if (k > 0 && $urandom_range(0, 2) == 0) t_addr[k] = t_addr[k-1];
                else t_addr[k] = word_t'($urandom) & 32'hFFFF_FFFC;
                t_store[k] = $urandom;
                t_wait[k]  = $urandom_range(0, 2);
            end
            kill = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            applyStimulus(vec, wr, int'($urandom_range(0, 3)), kill, -1);
        end

        // dhalt raised during lane 1: access completes, then HALT until reset
        set_lanes(32'h400, 32'h404, 32'h408, 32'h40C, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, -1, 0, 1);
        @(negedge CLK);
        for (int c = 0; c < 4; c++) begin
            bus.readReq = 1'b1;
            bus.flushed = (c >= 1);
            poke_inst(1'b1, 1'b1);
            checkOutput("halt_chalt",   CW'(bus.chalt),   CW'(1));
            checkOutput("halt_dmemREN", CW'(bus.dmemREN), CW'(0));
            checkOutput("halt_dmemWEN", CW'(bus.dmemWEN), CW'(0));
            checkOutput("halt_dHit",    CW'(bus.dHit),    CW'(0));
            @(negedge CLK);
        end
        do_reset();
        checkOutput("post_halt_chalt", CW'(bus.chalt), CW'(0));
        poke_inst(1'b0, 1'b1);
        check_loads();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
